// File: rtl/gray_ctrl_pkg.sv
// Shared encodings for the Gray-code counter controller.
// Command opcodes and FSM state codes live here so the top and its bench agree.
package gray_ctrl_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_NOP   = 2'b00;
    localparam op_t OP_LOAD  = 2'b01;
    localparam op_t OP_RUN   = 2'b10;
    localparam op_t OP_CLEAR = 2'b11;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/gray_step.sv
// Combinational next-value generator: optionally steps a binary count up/down
// and produces the matching Gray code, so both outputs always come from one source.
module gray_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    input  logic             dir_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o
);

    always_comb begin
        bin_o = bin_i;
        if (step_i) begin
            if (dir_i) begin
                bin_o = bin_i + WIDTH'(1);
            end else begin
                bin_o = bin_i - WIDTH'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_o[gi] = bin_o[gi] ^ bin_o[gi+1];
        end
    endgenerate

    assign gray_o[WIDTH-1] = bin_o[WIDTH-1];

endmodule

// File: rtl/gray_counter_ctrl.sv
// Command-driven Gray-code counter: LOAD/CLEAR in IDLE, RUN steps N times with
// hold/abort, then a one-cycle DONE pulse before returning to IDLE.
module gray_counter_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;

    logic [WIDTH-1:0] step_bin_in;
    logic             step_en;
    logic             update_en;
    logic [WIDTH-1:0] step_bin_out;
    logic [WIDTH-1:0] step_gray_out;
    logic             cmd_accept;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;

    // LOAD and CLEAR pass their value through the stepper unstepped, so the
    // Gray register is always derived from the same binary value it pairs with.
    gray_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .bin_i  (step_bin_in),
        .dir_i  (dir_q),
        .step_i (step_en),
        .bin_o  (step_bin_out),
        .gray_o (step_gray_out)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dir_d       = dir_q;
        step_bin_in = bin_q;
        step_en     = 1'b0;
        update_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            step_bin_in = cmd_arg;
                            update_en   = 1'b1;
                        end
                        OP_CLEAR: begin
                            step_bin_in = '0;
                            update_en   = 1'b1;
                        end
                        OP_RUN: begin
                            dir_d   = cmd_dir;
                            rem_d   = cmd_arg;
                            state_d = (cmd_arg == '0) ? ST_DONE : ST_RUN;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_RUN: begin
                if (abort) begin
                    rem_d   = '0;
                    state_d = ST_DONE;
                end else if (!hold) begin
                    step_en   = 1'b1;
                    update_en = 1'b1;
                    rem_d     = rem_q - WIDTH'(1);
                    if (rem_q == WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bin_d  = update_en ? step_bin_out  : bin_q;
        gray_d = update_en ? step_gray_out : gray_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);

endmodule

// File: doc/gray_counter_ctrl.md
GRAY_COUNTER_CTRL -- requirements
Module: gray_counter_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, giving the counter and step-count width in bits.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous and active-low (asserted when 0).
REQ-004 SHALL provide port cmd_valid  input  1  command offered.
REQ-005 SHALL provide port cmd_ready  output  1  command accepted this cycle when cmd_valid&cmd_ready.
REQ-006 SHALL provide port cmd_op  input  2  00 NOP, 01 LOAD, 10 RUN, 11 CLEAR.
REQ-007 SHALL provide port cmd_dir  input  1  RUN direction: 1 up, 0 down.
REQ-008 SHALL provide port cmd_arg  input  WIDTH  LOAD: binary start value; RUN: step count.
REQ-009 SHALL provide port hold  input  1  freeze stepping while in RUN.
REQ-010 SHALL provide port abort  input  1  terminate RUN early.
REQ-011 SHALL provide port gray_out  output  WIDTH  registered Gray-coded count.
REQ-012 SHALL provide port bin_out  output  WIDTH  registered binary equivalent of gray_out.
REQ-013 SHALL provide port busy  output  1  high in RUN state.
REQ-014 SHALL provide port done  output  1  one-cycle pulse when a RUN ends (normally or aborted).

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; cmd_ready = 1 only in IDLE.
REQ-016 SHALL, on accepted LOAD, set bin_out=cmd_arg and gray_out=cmd_arg^(cmd_arg>>1) next cycle, remaining in IDLE.
REQ-017 SHALL, on accepted CLEAR, set both outputs to 0 next cycle, remaining in IDLE.
REQ-018 SHALL treat accepted NOP as no operation.
REQ-019 SHALL, on accepted RUN with cmd_arg=N>0, latch N and cmd_dir and enter RUN; the first step occurs on the edge after entry.
REQ-020 SHALL, in RUN with hold=0 and abort=0, advance the count by exactly one binary step per cycle (modulo 2^WIDTH) and decrement the remaining count.
REQ-021 SHALL guarantee successive gray_out values differ in exactly one bit, including wrap 2^WIDTH-1 -> 0 (up) and 0 -> 2^WIDTH-1 (down).
REQ-022 SHALL, on the cycle the Nth step is applied, transition to DONE; DONE asserts done for one cycle then returns to IDLE.
REQ-023 SHALL, on accepted RUN with N=0, go directly to DONE without changing the count.
REQ-024 SHALL, with hold=1 in RUN, keep count and remaining steps unchanged.
REQ-025 SHALL, with abort=1 in RUN, go to DONE without stepping that cycle; abort has priority over hold; abort ignored outside RUN.
REQ-026 SHALL keep bin_out and gray_out mutually consistent (gray_out == bin_out^(bin_out>>1)) every cycle.
REQ-027 SHALL ensure a command offered while cmd_ready=0 is not consumed; a requester holds cmd_valid until accepted.

Reset
REQ-028 SHALL, when rst=0 at a rising clk edge, force state IDLE, gray_out=0, bin_out=0, busy=0, done=0, remaining count=0.
REQ-029 SHALL give reset priority over every command, abort and hold, including mid-RUN; cmd_ready=1 on the first cycle after rst returns to 1.

Structure
REQ-030 SHALL place the op encodings (NOP/LOAD/RUN/CLEAR) and state encodings in a shared package gray_ctrl_pkg.
REQ-031 SHALL instantiate one sub-module gray_step (combinational: binary in, dir in -> next binary and its Gray code), used for every update.

Verification
REQ-032 SHALL cover: reset, LOAD arg=5 -> bin_out=0101, gray_out=0111 next cycle; cmd_ready stays 1.
REQ-033 SHALL cover: from 0, RUN up N=16 -> gray_out 0000,0001,0011,0010,...,1000,0000; exactly one bit change per step; done pulse once after 16 steps, busy high 16 cycles.
REQ-034 SHALL cover: LOAD 0 then RUN down N=2 -> bin_out 15 then 14 (gray 1000, 1001); done pulses once.
REQ-035 SHALL cover: RUN up N=4 with hold=1 for 3 cycles mid-run -> busy lasts 7 cycles, final bin_out=start+4.
REQ-036 SHALL cover: RUN up N=10 with abort after 3 steps -> bin_out=start+3, done pulses, cmd_ready returns; also RUN N=0 -> done next cycle, count unchanged.
REQ-037 SHALL cover: rst=0 asserted mid-RUN -> all outputs 0 and state IDLE after that edge; cmd_valid ignored while cmd_ready=0.
